// File: rtl/pwm_period_meter.sv
// Multi-channel PWM meter: per-channel high/low/period capture plus a 2^AVG_LOG2-period average.
// Define PWM_GLITCH_FILTER_EN to add a FILTER_LEN-cycle stability filter after the synchroniser.
module pwm_period_meter #(
  parameter int NUM_CH      = 2,
  parameter int CNT_W       = 32,
  parameter int AVG_LOG2    = 4,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                      pwd_clk,
  input  logic                      sysreset,
  input  logic [NUM_CH-1:0]         sensor_input,
  output logic [NUM_CH*CNT_W-1:0]   high_count,
  output logic [NUM_CH*CNT_W-1:0]   low_count,
  output logic [NUM_CH*CNT_W-1:0]   period_count,
  output logic [NUM_CH*CNT_W-1:0]   average_out,
  output logic [NUM_CH-1:0]         period_valid,
  output logic [NUM_CH-1:0]         avg_valid,
  output logic [NUM_CH-1:0]         stuck_flag
);

  // state       | meaning
  // S_WAIT_RISE | after reset; falls ignored, any partial phase discarded
  // S_HIGH      | timing the high phase
  // S_LOW       | timing the low phase; next rise completes a period
  typedef enum logic [1:0] {
    S_WAIT_RISE = 2'd0,
    S_HIGH      = 2'd1,
    S_LOW       = 2'd2
  } state_t;

  localparam int ACC_W = CNT_W + AVG_LOG2;
  localparam int AVG_N = 1 << AVG_LOG2;
`ifdef PWM_GLITCH_FILTER_EN
  localparam int ARM_CYC = SYNC_STAGES + FILTER_LEN + 1;
`else
  localparam int ARM_CYC = SYNC_STAGES + 1;
`endif
  localparam int ARM_W = $clog2(ARM_CYC + 1);

  if (SYNC_STAGES < 2 || AVG_LOG2 < 1 || FILTER_LEN < 1) begin : g_bad_param
    $error("pwm_period_meter: SYNC_STAGES>=2, AVG_LOG2>=1, FILTER_LEN>=1 required");
  end

  // Edge detection stays off until the level path holds real pin data, so a pin
  // already high when reset releases is not mistaken for a rise.
  logic [ARM_W-1:0] r_arm_cnt;
  logic             w_armed;

  assign w_armed = (r_arm_cnt == ARM_W'(ARM_CYC));

  always_ff @(posedge pwd_clk) begin
    if (sysreset)      r_arm_cnt <= '0;
    else if (!w_armed) r_arm_cnt <= r_arm_cnt + 1'b1;
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_lvl;
    logic                   r_lvl_d;
    logic                   w_rise;
    logic                   w_fall;
    logic [CNT_W-1:0]       r_run;
    logic                   r_stuck;
    state_t                 r_state;
    logic [CNT_W-1:0]       r_high;
    logic [CNT_W-1:0]       r_low;
    logic [CNT_W-1:0]       r_per;
    logic [CNT_W-1:0]       r_avg;
    logic                   r_pv;
    logic                   r_av;
    logic [ACC_W-1:0]       r_acc;
    logic [AVG_LOG2-1:0]    r_acnt;
    logic [CNT_W:0]         w_per_sum;
    logic [CNT_W-1:0]       w_per_sat;
    logic [ACC_W-1:0]       w_acc_sum;

    always_ff @(posedge pwd_clk) begin
      if (sysreset) r_sync <= '0;
      else          r_sync <= {r_sync[SYNC_STAGES-2:0], sensor_input[i]};
    end

`ifdef PWM_GLITCH_FILTER_EN
    localparam int FW = $clog2(FILTER_LEN + 1);
    logic          r_lvl;
    logic [FW-1:0] r_filt;

    always_ff @(posedge pwd_clk) begin
      if (sysreset) begin
        r_lvl  <= 1'b0;
        r_filt <= '0;
      end else if (r_sync[SYNC_STAGES-1] == r_lvl) begin
        r_filt <= '0;
      end else if (r_filt == FW'(FILTER_LEN - 1)) begin
        r_lvl  <= r_sync[SYNC_STAGES-1];
        r_filt <= '0;
      end else begin
        r_filt <= r_filt + 1'b1;
      end
    end

    assign w_lvl = r_lvl;
`else
    assign w_lvl = r_sync[SYNC_STAGES-1];
`endif

    assign w_rise = w_armed &  w_lvl & ~r_lvl_d;
    assign w_fall = w_armed & ~w_lvl &  r_lvl_d;

    always_ff @(posedge pwd_clk) begin
      if (sysreset) begin
        r_lvl_d <= 1'b0;
        r_run   <= '0;
        r_stuck <= 1'b0;
      end else begin
        r_lvl_d <= w_lvl;
        if (w_rise || w_fall) begin
          r_run   <= CNT_W'(1);
          r_stuck <= 1'b0;
        end else if (r_run != '1) begin
          r_run   <= r_run + 1'b1;
        end else begin
          r_stuck <= 1'b1;
        end
      end
    end

    // Period saturates rather than wraps when the high phase was already stuck.
    assign w_per_sum = {1'b0, r_high} + {1'b0, r_run};
    assign w_per_sat = w_per_sum[CNT_W] ? '1 : w_per_sum[CNT_W-1:0];
    assign w_acc_sum = r_acc + ACC_W'(w_per_sat);

    always_ff @(posedge pwd_clk) begin
      if (sysreset) begin
        r_state <= S_WAIT_RISE;
        r_high  <= '0;
        r_low   <= '0;
        r_per   <= '0;
        r_avg   <= '0;
        r_pv    <= 1'b0;
        r_av    <= 1'b0;
        r_acc   <= '0;
        r_acnt  <= '0;
      end else begin
        r_pv <= 1'b0;
        r_av <= 1'b0;
        case (r_state)
          S_WAIT_RISE: if (w_rise) r_state <= S_HIGH;
          S_HIGH: begin
            if (w_fall) begin
              r_high  <= r_run;
              r_state <= S_LOW;
            end
          end
          S_LOW: begin
            if (w_rise) begin
              r_low   <= r_run;
              r_per   <= w_per_sat;
              r_pv    <= 1'b1;
              r_state <= S_HIGH;
              if (r_acnt == AVG_LOG2'(AVG_N - 1)) begin
                r_avg  <= w_acc_sum[ACC_W-1:AVG_LOG2];
                r_av   <= 1'b1;
                r_acc  <= '0;
                r_acnt <= '0;
              end else begin
                r_acc  <= w_acc_sum;
                r_acnt <= r_acnt + 1'b1;
              end
            end
          end
          default: r_state <= S_WAIT_RISE;
        endcase
      end
    end

    assign high_count[i*CNT_W +: CNT_W]   = r_high;
    assign low_count[i*CNT_W +: CNT_W]    = r_low;
    assign period_count[i*CNT_W +: CNT_W] = r_per;
    assign average_out[i*CNT_W +: CNT_W]  = r_avg;
    assign period_valid[i]                = r_pv;
    assign avg_valid[i]                   = r_av;
    assign stuck_flag[i]                  = r_stuck;
  end

endmodule

// File: tb/tb_pwm_period_meter.sv
// Bench for pwm_period_meter: pin-level generator, segment-length reference model, scenario tasks.
// Glitch scenario expectations follow PWM_GLITCH_FILTER_EN.
module tb_pwm_period_meter;
  localparam int NCH = 2;
  localparam int CW  = 16;
  localparam int AL  = 2;
  localparam int SAT = 65535;

  logic              pwd_clk = 1'b0;
  logic              sysreset = 1'b1;
  logic [NCH-1:0]    sensor_input = '0;
  logic [NCH*CW-1:0] high_count, low_count, period_count, average_out;
  logic [NCH-1:0]    period_valid, avg_valid, stuck_flag;

  pwm_period_meter #(
    .NUM_CH(NCH), .CNT_W(CW), .AVG_LOG2(AL), .SYNC_STAGES(2), .FILTER_LEN(4)
  ) dut (
    .pwd_clk(pwd_clk), .sysreset(sysreset), .sensor_input(sensor_input),
    .high_count(high_count), .low_count(low_count), .period_count(period_count),
    .average_out(average_out), .period_valid(period_valid), .avg_valid(avg_valid),
    .stuck_flag(stuck_flag)
  );

  always #5 pwd_clk = ~pwd_clk;

  int n_vec = 0;
  int n_err = 0;
  int n_coinc = 0;
  bit g_chk = 1'b0;

  typedef struct { int ch; int hi; int lo; int per; } rec_t;
  typedef struct { int ch; int avg; } avg_t;
  rec_t exp_q[$], obs_q[$];
  avg_t expa_q[$], obsa_q[$];

  // Generator state: per channel, fixed or random phase lengths.
  logic [1:0] g_lvl;
  int g_h[2], g_l[2], g_left[2];
  bit g_en[2], g_rnd[2];

  // Reference model: phase length = number of clock samples the pin held a level.
  logic [1:0] m_lvl;
  int m_st[2], m_len[2], m_hi[2], m_sum[2], m_n[2];

  initial begin : model
    int cap, per;
    rec_t r;
    avg_t a;
    forever begin
      @(posedge pwd_clk);
      if (sysreset) begin
        for (int c = 0; c < NCH; c++) begin
          m_lvl[c] = sensor_input[c];
          m_st[c] = 0; m_len[c] = 0; m_hi[c] = 0; m_sum[c] = 0; m_n[c] = 0;
        end
        exp_q.delete();
        expa_q.delete();
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (sensor_input[c] != m_lvl[c]) begin
            cap = (m_len[c] > SAT) ? SAT : m_len[c];
            if (sensor_input[c]) begin
              if (m_st[c] == 2) begin
                per = m_hi[c] + cap;
                if (per > SAT) per = SAT;
                r.ch = c; r.hi = m_hi[c]; r.lo = cap; r.per = per;
                exp_q.push_back(r);
                m_sum[c] += per;
                m_n[c]++;
                if (m_n[c] == (1 << AL)) begin
                  a.ch = c; a.avg = m_sum[c] / (1 << AL);
                  expa_q.push_back(a);
                  m_sum[c] = 0; m_n[c] = 0;
                end
              end
              m_st[c] = 1;
            end else if (m_st[c] == 1) begin
              m_hi[c] = cap;
              m_st[c] = 2;
            end
            m_lvl[c] = sensor_input[c];
            m_len[c] = 1;
          end else if (m_len[c] < SAT) begin
            m_len[c]++;
          end
        end
      end
    end
  end

  initial begin : monitor
    int idx;
    rec_t o, e;
    avg_t oa, ea;
    forever begin
      @(negedge pwd_clk);
      if (!sysreset) begin
        if (period_valid == 2'b11) n_coinc++;
        for (int c = 0; c < NCH; c++) begin
          if (period_valid[c]) begin
            o.ch = c; o.hi = int'(high_count[c*CW +: CW]);
            o.lo = int'(low_count[c*CW +: CW]); o.per = int'(period_count[c*CW +: CW]);
            obs_q.push_back(o);
            if (g_chk) begin
              idx = -1;
              foreach (exp_q[k]) if (idx < 0 && exp_q[k].ch == c) idx = k;
              n_vec++;
              if (idx < 0) begin
                n_err++;
                $display("FAIL period_unexpected ch%0d got hi=%0d lo=%0d per=%0d, expected no report",
                         c, o.hi, o.lo, o.per);
              end else begin
                e = exp_q[idx];
                exp_q.delete(idx);
                if (o.hi !== e.hi || o.lo !== e.lo || o.per !== e.per) begin
                  n_err++;
                  $display("FAIL period_values ch%0d got hi=%0d lo=%0d per=%0d, expected hi=%0d lo=%0d per=%0d",
                           c, o.hi, o.lo, o.per, e.hi, e.lo, e.per);
                end
              end
            end
          end
          if (avg_valid[c]) begin
            oa.ch = c; oa.avg = int'(average_out[c*CW +: CW]);
            obsa_q.push_back(oa);
            if (g_chk) begin
              idx = -1;
              foreach (expa_q[k]) if (idx < 0 && expa_q[k].ch == c) idx = k;
              n_vec++;
              if (idx < 0) begin
                n_err++;
                $display("FAIL avg_unexpected ch%0d got avg=%0d, expected no report", c, oa.avg);
              end else begin
                ea = expa_q[idx];
                expa_q.delete(idx);
                if (oa.avg !== ea.avg || !period_valid[c]) begin
                  n_err++;
                  $display("FAIL avg_value ch%0d got avg=%0d pv=%0b, expected avg=%0d pv=1",
                           c, oa.avg, period_valid[c], ea.avg);
                end
              end
            end
          end
        end
      end
    end
  end

  task automatic reset_dut(input int n, input logic [1:0] pins);
    sysreset = 1'b1;
    sensor_input = pins;
    g_lvl = pins;
    for (int c = 0; c < NCH; c++) begin
      g_en[c] = 1'b0; g_rnd[c] = 1'b0; g_left[c] = 0; g_h[c] = 10; g_l[c] = 30;
    end
    repeat (n) begin @(posedge pwd_clk); #1; end
    sysreset = 1'b0;
    obs_q.delete();
    obsa_q.delete();
    n_coinc = 0;
    g_chk = 1'b1;
  endtask

  task automatic play(input int cycles);
    for (int t = 0; t < cycles; t++) begin
      for (int c = 0; c < NCH; c++) begin
        if (g_en[c]) begin
          if (g_left[c] == 0) begin
            g_lvl[c] = ~g_lvl[c];
            if (g_rnd[c]) begin
              if (g_lvl[c]) g_h[c] = int'($urandom_range(5, 60));
              else          g_l[c] = int'($urandom_range(5, 60));
            end
            g_left[c] = g_lvl[c] ? g_h[c] : g_l[c];
          end
          g_left[c]--;
        end
      end
      sensor_input = g_lvl;
      @(posedge pwd_clk); #1;
    end
  endtask

  function automatic int count_ch(input int c);
    int n = 0;
    foreach (obs_q[k]) if (obs_q[k].ch == c) n++;
    return n;
  endfunction

  task automatic test_reset();
    reset_dut(3, 2'b11);
    @(negedge pwd_clk);
    n_vec += 4;
    if (high_count !== '0 || low_count !== '0) begin
      n_err++; $display("FAIL reset_hl got high=%h low=%h, expected 0", high_count, low_count);
    end
    if (period_count !== '0 || average_out !== '0) begin
      n_err++; $display("FAIL reset_pa got per=%h avg=%h, expected 0", period_count, average_out);
    end
    if (period_valid !== '0 || avg_valid !== '0) begin
      n_err++; $display("FAIL reset_valid got pv=%b av=%b, expected 0", period_valid, avg_valid);
    end
    if (stuck_flag !== '0) begin
      n_err++; $display("FAIL reset_stuck got %b, expected 0", stuck_flag);
    end
  endtask

  task automatic test_partial_start();
    reset_dut(2, 2'b01);
    play(20);
    g_lvl[0] = 1'b0;
    play(20);
    g_en[0] = 1'b1;
    play(82);
    g_en[0] = 1'b0;
    play(8);
    n_vec += 2;
    if (count_ch(0) !== 2) begin
      n_err++; $display("FAIL partial_count got %0d periods, expected 2", count_ch(0));
    end else if (obs_q[0].hi !== 10 || obs_q[0].lo !== 30 || obs_q[0].per !== 40) begin
      n_err++; $display("FAIL partial_first got hi=%0d lo=%0d per=%0d, expected 10/30/40",
                        obs_q[0].hi, obs_q[0].lo, obs_q[0].per);
    end
  endtask

  task automatic test_basic();
    reset_dut(2, 2'b00);
    play(12);
    g_en[0] = 1'b1;
    play(8 * 40 + 1);
    g_en[0] = 1'b0;
    play(8);
    n_vec++;
    if (count_ch(0) !== 8) begin
      n_err++; $display("FAIL basic_count got %0d periods, expected 8", count_ch(0));
    end
    foreach (obs_q[k]) begin
      n_vec++;
      if (obs_q[k].hi !== 10 || obs_q[k].lo !== 30 || obs_q[k].per !== 40) begin
        n_err++; $display("FAIL basic_period got hi=%0d lo=%0d per=%0d, expected 10/30/40",
                          obs_q[k].hi, obs_q[k].lo, obs_q[k].per);
      end
    end
    n_vec++;
    if (obsa_q.size() !== 2) begin
      n_err++; $display("FAIL basic_avg_count got %0d, expected 2", obsa_q.size());
    end
    foreach (obsa_q[k]) begin
      n_vec++;
      if (obsa_q[k].avg !== 40) begin
        n_err++; $display("FAIL basic_avg got %0d, expected 40", obsa_q[k].avg);
      end
    end
  endtask

  task automatic test_average();
    reset_dut(2, 2'b00);
    play(12);
    g_en[0] = 1'b1;
    g_h[0] = 20;
    for (int k = 0; k < 4; k++) begin
      g_l[0] = 20 + 4 * k;
      play(40 + 4 * k);
    end
    g_l[0] = 20;
    play(2);
    g_en[0] = 1'b0;
    play(8);
    n_vec += 2;
    if (obsa_q.size() !== 1 || obsa_q[0].avg !== 46) begin
      n_err++; $display("FAIL avg_46 got %0d averages (first=%0d), expected 1 of 46",
                        obsa_q.size(), (obsa_q.size() > 0) ? obsa_q[0].avg : -1);
    end
    if (obs_q.size() !== 4 || obs_q[3].per !== 52) begin
      n_err++; $display("FAIL avg_last_period got %0d periods, expected 4 ending in 52", obs_q.size());
    end
  endtask

  task automatic test_reset_mid_low();
    reset_dut(2, 2'b00);
    play(12);
    g_en[0] = 1'b1;
    play(3 * 40 + 15);
    sysreset = 1'b1;
    @(posedge pwd_clk); #1;
    sysreset = 1'b0;
    obs_q.delete();
    @(negedge pwd_clk);
    n_vec += 2;
    if (high_count !== '0 || low_count !== '0 || period_count !== '0 || average_out !== '0) begin
      n_err++; $display("FAIL midreset_out got high=%h low=%h per=%h avg=%h, expected 0",
                        high_count, low_count, period_count, average_out);
    end
    if (period_valid !== '0) begin
      n_err++; $display("FAIL midreset_pv got %b, expected 0", period_valid);
    end
    @(posedge pwd_clk); #1;
    play(30);
    n_vec++;
    if (obs_q.size() !== 0) begin
      n_err++; $display("FAIL midreset_early got %0d periods, expected 0", obs_q.size());
    end
    play(60);
    g_en[0] = 1'b0;
    play(8);
    n_vec++;
    if (obs_q.size() !== 1 || obs_q[0].per !== 40) begin
      n_err++; $display("FAIL midreset_first got %0d periods, expected 1 of 40", obs_q.size());
    end
  endtask

  task automatic test_two_ch();
    reset_dut(2, 2'b00);
    play(12);
    g_en[0] = 1'b1; g_en[1] = 1'b1;
    g_h[1] = 5; g_l[1] = 15;
    play(161);
    g_en[0] = 1'b0; g_en[1] = 1'b0;
    play(8);
    n_vec += 3;
    if (count_ch(0) !== 4 || count_ch(1) !== 8) begin
      n_err++; $display("FAIL two_count got ch0=%0d ch1=%0d, expected 4 and 8", count_ch(0), count_ch(1));
    end
    if (n_coinc !== 4) begin
      n_err++; $display("FAIL two_coincident got %0d, expected 4", n_coinc);
    end
    if (obsa_q.size() !== 3) begin
      n_err++; $display("FAIL two_avg_count got %0d, expected 3", obsa_q.size());
    end
    foreach (obs_q[k]) begin
      if (obs_q[k].ch == 1) begin
        n_vec++;
        if (obs_q[k].hi !== 5 || obs_q[k].lo !== 15 || obs_q[k].per !== 20) begin
          n_err++; $display("FAIL two_ch1 got hi=%0d lo=%0d per=%0d, expected 5/15/20",
                            obs_q[k].hi, obs_q[k].lo, obs_q[k].per);
        end
      end
    end
  endtask

  task automatic test_glitch();
    reset_dut(2, 2'b00);
    g_chk = 1'b0;
    play(12);
    g_lvl[0] = 1'b1; play(9);
    g_lvl[0] = 1'b0; play(2);
    g_lvl[0] = 1'b1; play(9);
    g_lvl[0] = 1'b0; play(30);
    g_lvl[0] = 1'b1; play(12);
`ifdef PWM_GLITCH_FILTER_EN
    n_vec++;
    if (obs_q.size() !== 1 || obs_q[0].hi !== 20 || obs_q[0].lo !== 30 || obs_q[0].per !== 50) begin
      n_err++; $display("FAIL glitch_filtered got %0d periods (first hi=%0d), expected 1 of 20/30/50",
                        obs_q.size(), (obs_q.size() > 0) ? obs_q[0].hi : -1);
    end
`else
    n_vec++;
    if (obs_q.size() !== 2 || obs_q[0].hi !== 9 || obs_q[0].lo !== 2 || obs_q[0].per !== 11 ||
        obs_q[1].hi !== 9 || obs_q[1].lo !== 30 || obs_q[1].per !== 39) begin
      n_err++; $display("FAIL glitch_split got %0d periods, expected 9/2/11 then 9/30/39", obs_q.size());
    end
`endif
    g_chk = 1'b1;
  endtask

  task automatic test_random();
    reset_dut(2, 2'b00);
    play(12);
    g_en[0] = 1'b1; g_en[1] = 1'b1;
    g_rnd[0] = 1'b1; g_rnd[1] = 1'b1;
    play(3000);
    g_en[0] = 1'b0; g_en[1] = 1'b0;
    play(10);
    n_vec += 2;
    if (exp_q.size() !== 0 || expa_q.size() !== 0) begin
      n_err++; $display("FAIL random_missing got %0d periods and %0d averages unreported, expected 0",
                        exp_q.size(), expa_q.size());
    end
    if (count_ch(0) < 20 || count_ch(1) < 20) begin
      n_err++; $display("FAIL random_count got ch0=%0d ch1=%0d, expected at least 20 each",
                        count_ch(0), count_ch(1));
    end
  endtask

  task automatic test_stuck();
    reset_dut(2, 2'b00);
    play(12);
    g_lvl[0] = 1'b1;
    play(70000);
    n_vec++;
    if (stuck_flag[0] !== 1'b1) begin
      n_err++; $display("FAIL stuck_set got %b, expected 1", stuck_flag[0]);
    end
    g_lvl[0] = 1'b0;
    play(30);
    n_vec += 2;
    if (stuck_flag[0] !== 1'b0) begin
      n_err++; $display("FAIL stuck_clear got %b, expected 0", stuck_flag[0]);
    end
    if (high_count[CW-1:0] !== 16'hFFFF) begin
      n_err++; $display("FAIL stuck_high got %h, expected ffff", high_count[CW-1:0]);
    end
    g_lvl[0] = 1'b1;
    play(8);
    n_vec++;
    if (period_count[CW-1:0] !== 16'hFFFF || low_count[CW-1:0] !== 16'd30) begin
      n_err++; $display("FAIL stuck_period got per=%h low=%0d, expected ffff and 30",
                        period_count[CW-1:0], low_count[CW-1:0]);
    end
  endtask

  initial begin
    test_reset();
    test_partial_start();
    test_basic();
    test_average();
    test_reset_mid_low();
    test_two_ch();
    test_glitch();
    test_random();
    test_stuck();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
